// File: rtl/mem_resp_arb.sv
// mem_resp_arb: three-initiator req/gnt/rvalid responder in front of a single-port
// SRAM with one-cycle read latency.
//
// Ports:
//   clk_sys, rst_sys_n          clock, async active-low reset
//   instr_*                     instruction port (read-only, byte address)
//   data_*                      data port (byte enables, byte address)
//   cust_*                      custom-extension port (word index, always in range)
//   ram_*                       single-port SRAM interface
//
// Arbitration is combinational (grant in the request cycle). Base priority is
// instr > data > cust; data/cust carry starvation counters that, once at the
// limit, lift the port above instr (data before cust). The response register
// records which port was granted and whether the access was out of range; it
// drives exactly one rvalid the following cycle.
module mem_resp_arb #(
    parameter int unsigned MEM_SIZE     = 65536,
    parameter logic [31:0] MEM_START    = 32'h0000_0000,
    parameter int unsigned AW           = 14,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,

    input  logic          instr_req_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    input  logic [31:0]   instr_addr_i,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,

    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    input  logic          cust_req_i,
    output logic          cust_gnt_o,
    output logic          cust_rvalid_o,
    input  logic          cust_we_i,
    input  logic [AW-1:0] cust_addr_i,
    input  logic [31:0]   cust_wdata_i,
    output logic [31:0]   cust_rdata_o,

    output logic          ram_req_o,
    output logic          ram_we_o,
    output logic [3:0]    ram_be_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rdata_i
);

    typedef enum logic [1:0] {
        PortNone  = 2'd0,
        PortInstr = 2'd1,
        PortData  = 2'd2,
        PortCust  = 2'd3
    } port_e;

    localparam logic [31:0] AddrMask  = ~(32'(MEM_SIZE) - 32'd1);
    localparam logic [3:0]  StarveLim = 4'(STARVE_LIMIT);

    logic [3:0] data_cnt_q, data_cnt_d;
    logic [3:0] cust_cnt_q, cust_cnt_d;
    port_e      rsp_port_q, rsp_port_d;
    logic       rsp_err_q, rsp_err_d;

    port_e      win;
    logic       data_boost, cust_boost;
    logic       instr_in_range, data_in_range;

    assign instr_in_range = (instr_addr_i & AddrMask) == MEM_START;
    assign data_in_range  = (data_addr_i & AddrMask) == MEM_START;

    // A boosted port still needs a live request; a stale count alone never wins.
    assign data_boost = data_req_i && (data_cnt_q >= StarveLim);
    assign cust_boost = cust_req_i && (cust_cnt_q >= StarveLim);

    always_comb begin
        win = PortNone;
        if (!rst_sys_n) begin
            win = PortNone;
        end else if (data_boost) begin
            win = PortData;
        end else if (cust_boost) begin
            win = PortCust;
        end else if (instr_req_i) begin
            win = PortInstr;
        end else if (data_req_i) begin
            win = PortData;
        end else if (cust_req_i) begin
            win = PortCust;
        end
    end

    assign instr_gnt_o = (win == PortInstr);
    assign data_gnt_o  = (win == PortData);
    assign cust_gnt_o  = (win == PortCust);

    // SRAM strobe; out-of-range accesses are granted but never reach the SRAM.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        rsp_err_d   = 1'b0;
        unique case (win)
            PortInstr: begin
                if (instr_in_range) begin
                    ram_req_o  = 1'b1;
                    ram_be_o   = 4'hF;
                    ram_addr_o = instr_addr_i[AW+1:2];
                end else begin
                    rsp_err_d = 1'b1;
                end
            end
            PortData: begin
                if (data_in_range) begin
                    ram_req_o   = 1'b1;
                    ram_we_o    = data_we_i;
                    ram_be_o    = data_be_i;
                    ram_addr_o  = data_addr_i[AW+1:2];
                    ram_wdata_o = data_wdata_i;
                end else begin
                    rsp_err_d = 1'b1;
                end
            end
            PortCust: begin
                ram_req_o   = 1'b1;
                ram_we_o    = cust_we_i;
                ram_be_o    = 4'hF;
                ram_addr_o  = cust_addr_i;
                ram_wdata_o = cust_wdata_i;
            end
            default: ;
        endcase
        rsp_port_d = win;
    end

    // Saturating starvation counters: count lost cycles, clear on grant or idle.
    always_comb begin
        data_cnt_d = 4'h0;
        cust_cnt_d = 4'h0;
        if (data_req_i && (win != PortData)) begin
            data_cnt_d = (data_cnt_q == 4'hF) ? data_cnt_q : data_cnt_q + 4'd1;
        end
        if (cust_req_i && (win != PortCust)) begin
            cust_cnt_d = (cust_cnt_q == 4'hF) ? cust_cnt_q : cust_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            data_cnt_q <= 4'h0;
            cust_cnt_q <= 4'h0;
            rsp_port_q <= PortNone;
            rsp_err_q  <= 1'b0;
        end else begin
            data_cnt_q <= data_cnt_d;
            cust_cnt_q <= cust_cnt_d;
            rsp_port_q <= rsp_port_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign instr_rvalid_o = (rsp_port_q == PortInstr);
    assign data_rvalid_o  = (rsp_port_q == PortData);
    assign cust_rvalid_o  = (rsp_port_q == PortCust);

    assign instr_err_o = instr_rvalid_o && rsp_err_q;
    assign data_err_o  = data_rvalid_o && rsp_err_q;

    assign instr_rdata_o = (instr_rvalid_o && !rsp_err_q) ? ram_rdata_i : 32'h0;
    assign data_rdata_o  = (data_rvalid_o && !rsp_err_q) ? ram_rdata_i : 32'h0;
    assign cust_rdata_o  = cust_rvalid_o ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_resp_arb.sv
// Self-checking bench for mem_resp_arb: a bench-side SRAM, a transaction-level
// reference model checked every cycle, and directed scenarios with literal values.
module tb_mem_resp_arb;

    localparam int unsigned Words = 16384;
    localparam int unsigned Limit = 8;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = 32'h0;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        cust_req_i = 1'b0;
    logic        cust_we_i = 1'b0;
    logic [13:0] cust_addr_i = 14'h0;
    logic [31:0] cust_wdata_i = 32'h0;
    logic [31:0] ram_rdata_i = 32'h0;

    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        cust_gnt_o, cust_rvalid_o;
    logic [31:0] cust_rdata_o;
    logic        ram_req_o, ram_we_o;
    logic [3:0]  ram_be_o;
    logic [13:0] ram_addr_o;
    logic [31:0] ram_wdata_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sram      [Words];
    logic [31:0] model_mem [Words];

    mem_resp_arb dut (
        .clk_sys        (clk_sys),
        .rst_sys_n      (rst_sys_n),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .cust_req_i     (cust_req_i),
        .cust_gnt_o     (cust_gnt_o),
        .cust_rvalid_o  (cust_rvalid_o),
        .cust_we_i      (cust_we_i),
        .cust_addr_i    (cust_addr_i),
        .cust_wdata_i   (cust_wdata_i),
        .cust_rdata_o   (cust_rdata_o),
        .ram_req_o      (ram_req_o),
        .ram_we_o       (ram_we_o),
        .ram_be_o       (ram_be_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port SRAM: one-cycle read latency, read-before-write.
    always @(posedge clk_sys) begin
        if (ram_req_o) begin
            ram_rdata_i <= sram[ram_addr_o];
            if (ram_we_o) begin
                sram[ram_addr_o] <= (sram[ram_addr_o] & ~{{8{ram_be_o[3]}}, {8{ram_be_o[2]}},
                    {8{ram_be_o[1]}}, {8{ram_be_o[0]}}}) | (ram_wdata_o &
                    {{8{ram_be_o[3]}}, {8{ram_be_o[2]}}, {8{ram_be_o[1]}}, {8{ram_be_o[0]}}});
            end
        end
    end

    // Reference model: winner chosen from the priority rules, pending response
    // held for one cycle, expected memory image updated on modelled writes.
    int          m_win, m_pend, m_dcnt, m_ccnt, e_addr;
    logic        m_perr, e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] m_prd, e_wd, w;

    always @(negedge clk_sys) begin
        if (!rst_sys_n) begin
            chk("rst_ctl", 32'({instr_gnt_o, data_gnt_o, cust_gnt_o, instr_rvalid_o,
                data_rvalid_o, cust_rvalid_o, instr_err_o, data_err_o, ram_req_o}), 32'h0);
            chk("rst_rdata", instr_rdata_o | data_rdata_o | cust_rdata_o, 32'h0);
            m_pend = 0;
            m_dcnt = 0;
            m_ccnt = 0;
        end else begin
            chk("rvalid", 32'({instr_rvalid_o, data_rvalid_o, cust_rvalid_o}),
                32'({m_pend == 1, m_pend == 2, m_pend == 3}));
            chk("err", 32'({instr_err_o, data_err_o}),
                32'({m_pend == 1 && m_perr, m_pend == 2 && m_perr}));
            chk("instr_rdata", instr_rdata_o, (m_pend == 1 && !m_perr) ? m_prd : 32'h0);
            chk("data_rdata", data_rdata_o, (m_pend == 2 && !m_perr) ? m_prd : 32'h0);
            chk("cust_rdata", cust_rdata_o, (m_pend == 3) ? m_prd : 32'h0);

            if (data_req_i && m_dcnt >= Limit) m_win = 2;
            else if (cust_req_i && m_ccnt >= Limit) m_win = 3;
            else if (instr_req_i) m_win = 1;
            else if (data_req_i) m_win = 2;
            else if (cust_req_i) m_win = 3;
            else m_win = 0;
            chk("gnt", 32'({instr_gnt_o, data_gnt_o, cust_gnt_o}),
                32'({m_win == 1, m_win == 2, m_win == 3}));

            m_perr = 1'b0; m_prd = 32'h0;
            e_req = 1'b0; e_we = 1'b0; e_be = 4'h0; e_addr = 0; e_wd = 32'h0;
            if (m_win == 1) begin
                if (instr_addr_i < 32'h0001_0000) begin
                    e_req = 1'b1; e_addr = int'(instr_addr_i / 4); e_be = 4'hF;
                    m_prd = model_mem[e_addr];
                end else m_perr = 1'b1;
            end else if (m_win == 2) begin
                if (data_addr_i < 32'h0001_0000) begin
                    e_req = 1'b1; e_addr = int'(data_addr_i / 4); e_we = data_we_i;
                    e_be = data_be_i; e_wd = data_wdata_i;
                    m_prd = model_mem[e_addr];
                    if (data_we_i) begin
                        w = model_mem[e_addr];
                        for (int b = 0; b < 4; b++)
                            if (data_be_i[b]) w[8*b +: 8] = data_wdata_i[8*b +: 8];
                        model_mem[e_addr] = w;
                    end
                end else m_perr = 1'b1;
            end else if (m_win == 3) begin
                e_req = 1'b1; e_addr = int'(cust_addr_i); e_we = cust_we_i; e_be = 4'hF;
                e_wd = cust_wdata_i;
                m_prd = model_mem[e_addr];
                if (cust_we_i) model_mem[e_addr] = cust_wdata_i;
            end
            chk("ram_req", 32'(ram_req_o), 32'(e_req));
            if (e_req) begin
                chk("ram_addr", 32'(ram_addr_o), 32'(e_addr));
                chk("ram_we_be", 32'({ram_we_o, ram_be_o}), 32'({e_we, e_be}));
                if (e_we) chk("ram_wdata", ram_wdata_o, e_wd);
            end

            m_pend = m_win;
            m_dcnt = (data_req_i && m_win != 2) ? ((m_dcnt < 15) ? m_dcnt + 1 : 15) : 0;
            m_ccnt = (cust_req_i && m_win != 3) ? ((m_ccnt < 15) ? m_ccnt + 1 : 15) : 0;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        cust_req_i  = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 11) == 0)
            return ($urandom_range(0, 1) == 0) ? 32'h0001_0000 + 32'($urandom_range(0, 1023))
                                               : 32'h8000_0000 + 32'($urandom_range(0, 1023));
        return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    logic hi, hd, hc;

    initial begin
        for (int i = 0; i < int'(Words); i++) begin
            sram[i]      = 32'(i) * 32'h9E37_79B9;
            model_mem[i] = 32'(i) * 32'h9E37_79B9;
        end
        sram[32] = 32'hDEAD_BEEF; model_mem[32] = 32'hDEAD_BEEF;
        sram[65] = 32'h1122_3344; model_mem[65] = 32'h1122_3344;

        repeat (3) tick();
        rst_sys_n = 1'b1;
        tick();

        // Single read
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0080;
        @(negedge clk_sys);
        chk("rd_gnt", 32'(instr_gnt_o), 32'd1);
        chk("rd_ram_addr", 32'(ram_addr_o), 32'd32);
        tick(); idle();
        @(negedge clk_sys);
        chk("rd_rvalid", 32'(instr_rvalid_o), 32'd1);
        chk("rd_rdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("rd_err", 32'(instr_err_o), 32'd0);
        tick();

        // Byte write then readback
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0010;
        data_addr_i = 32'h104; data_wdata_i = 32'h0000_AB00;
        @(negedge clk_sys);
        chk("bw_gnt", 32'(data_gnt_o), 32'd1);
        tick(); idle();
        @(negedge clk_sys);
        chk("bw_rvalid", 32'(data_rvalid_o), 32'd1);
        tick();
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
        tick(); idle();
        @(negedge clk_sys);
        chk("bw_readback", data_rdata_o, 32'h1122_AB44);
        tick();

        // Contention: 8 instr grants, then boosted data, then boosted cust
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h104;
        cust_req_i = 1'b1; cust_we_i = 1'b0; cust_addr_i = 14'd5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_sys);
            chk($sformatf("arb_cycle%0d", k), 32'({cust_gnt_o, data_gnt_o, instr_gnt_o}),
                (k <= 8) ? 32'b001 : (k == 9) ? 32'b010 : 32'b100);
            tick();
        end
        idle();
        tick();

        // Out of range read and write
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0001_0000;
        @(negedge clk_sys);
        chk("oor_gnt", 32'(data_gnt_o), 32'd1);
        chk("oor_ram_req", 32'(ram_req_o), 32'd0);
        tick();
        data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h0001_0104;
        data_wdata_i = 32'hFFFF_FFFF;
        @(negedge clk_sys);
        chk("oor_resp", 32'({data_rvalid_o, data_err_o}), 32'b11);
        chk("oor_rdata", data_rdata_o, 32'h0);
        chk("oor_wr_ram_req", 32'(ram_req_o), 32'd0);
        tick();
        data_we_i = 1'b0; data_addr_i = 32'h104;
        tick(); idle();
        @(negedge clk_sys);
        chk("oor_wr_dropped", data_rdata_o, 32'h1122_AB44);
        tick();

        // Custom write then read at the top index
        cust_req_i = 1'b1; cust_we_i = 1'b1; cust_addr_i = 14'h3FFF;
        cust_wdata_i = 32'hCAFE_F00D;
        tick();
        cust_we_i = 1'b0;
        @(negedge clk_sys);
        chk("cust_wr_rvalid", 32'(cust_rvalid_o), 32'd1);
        tick(); idle();
        @(negedge clk_sys);
        chk("cust_rd_rvalid", 32'(cust_rvalid_o), 32'd1);
        chk("cust_rd_rdata", cust_rdata_o, 32'hCAFE_F00D);
        tick();

        // Reset in the cycle after a data grant
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h108;
        @(negedge clk_sys);
        chk("rm_gnt", 32'(data_gnt_o), 32'd1);
        tick();
        rst_sys_n = 1'b0; idle();
        @(negedge clk_sys);
        chk("rm_no_rvalid", 32'(data_rvalid_o), 32'd0);
        tick(); tick();
        rst_sys_n = 1'b1;
        @(negedge clk_sys);
        chk("rm_no_rvalid_after", 32'(data_rvalid_o), 32'd0);
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        tick(); idle();
        @(negedge clk_sys);
        chk("rm_fresh_read", instr_rdata_o, 32'hDEAD_BEEF);
        tick();

        // Randomized traffic; un-granted requests are held stable
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_sys);
            hi = instr_req_i && !instr_gnt_o;
            hd = data_req_i && !data_gnt_o;
            hc = cust_req_i && !cust_gnt_o;
            tick();
            if (!rst_sys_n) rst_sys_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_sys_n = 1'b0;
            if (!hi) begin
                instr_req_i = ($urandom_range(0, 2) != 0);
                instr_addr_i = rand_addr();
            end
            if (!hd) begin
                data_req_i = ($urandom_range(0, 2) != 0);
                data_we_i = 1'($urandom_range(0, 1));
                data_be_i = 4'($urandom_range(0, 15));
                data_addr_i = rand_addr();
                data_wdata_i = $urandom;
            end
            if (!hc) begin
                cust_req_i = ($urandom_range(0, 1) != 0);
                cust_we_i = 1'($urandom_range(0, 1));
                cust_addr_i = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 63));
                cust_wdata_i = $urandom;
            end
        end
        rst_sys_n = 1'b1;
        idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_resp_arb.md
# mem_resp_arb

Memory-side responder for the Ibex-style req/gnt/rvalid protocol. It serves three initiators from a single-port 32-bit SRAM with one-cycle read latency: the core instruction port, the core data port, and the custom-extension RAM port. The block sits between `ibex_core` and `ram_1p` in the top level, adds byte-enable writes and out-of-range error responses, and applies priority arbitration with starvation protection.

## Interface
- MEM_SIZE, 65536: SRAM size in bytes, power of two.
- MEM_START, 32'h0000_0000: base address, aligned to MEM_SIZE.
- AW, 14: word-address width, log2(MEM_SIZE/4).
- STARVE_LIMIT, 8: consecutive lost-arbitration cycles before a port is boosted, range 1..15.

Ports:
- clk_sys  in  1  system clock.
- rst_sys_n  in  1  reset, asynchronous, active-low.
- instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1 each  instruction handshake.
- instr_addr_i  in  32  byte address.
- instr_rdata_o  out  32  read data.
- instr_err_o  out  1  error, valid with rvalid.
- data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1 each  data handshake.
- data_we_i  in  1  write.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  error.
- cust_req_i / cust_gnt_o / cust_rvalid_o  in/out/out  1 each  custom-port handshake.
- cust_we_i  in  1  write.
- cust_addr_i  in  AW  word address, always in range.
- cust_wdata_i  in  32  write data.
- cust_rdata_o  out  32  read data.
- ram_req_o, ram_we_o  out  1 each  SRAM strobe and write.
- ram_be_o  out  4  SRAM byte enables.
- ram_addr_o  out  AW  SRAM word index.
- ram_wdata_o  out  32  SRAM write data.
- ram_rdata_i  in  32  SRAM read data, valid the cycle after ram_req_o.

## Operation
- Exactly one request is granted per cycle.
- The grant is combinational and is issued in the same cycle as the request.
- A request with req high and gnt low must be held stable by the initiator. The block does not latch it.
- Base priority: instr > data > cust.
- Starvation counters, one each for data and cust, 4 bits, saturating:
  - A counter increments on every cycle its port has req high and loses arbitration.
  - A counter clears on a grant to its port or when its req goes low.
  - When a counter is >= STARVE_LIMIT, that port outranks instr.
  - If both counters are at the limit, data wins over cust.
- Address check for instr/data: in range when (addr & ~(MEM_SIZE-1)) == MEM_START. The word index is addr[AW+1:2].
- In-range grant: ram_req_o=1 and ram_addr_o=index.
  - Data writes: ram_we_o=data_we_i, ram_be_o=data_be_i.
  - Instruction accesses: ram_we_o=0, ram_be_o=4'hF.
  - Custom writes: ram_be_o=4'hF.
- Out-of-range grant: the request is granted but ram_req_o=0. The response carries err=1 and rdata=0.
  - Out-of-range data writes are dropped.
- A read with data_be_i=0 is still performed. A write with data_be_i=0 asserts ram_req_o with ram_be_o=0.
- Response register: captures granted-port (2 bits) and err (1 bit).
  - The cycle after a grant, exactly one of the rvalid outputs pulses high.
  - Every granted access gets an rvalid pulse, reads and writes alike.
- rdata_o of the responding port is ram_rdata_i, or 0 on error. Non-responding rdata_o outputs and err outputs are 0.
- Back-to-back grants to the same port are allowed every cycle, so throughput is one access per cycle.

## Timing
- Reset (async assert, sync release):
  - Response register cleared.
  - Starvation counters cleared.
  - All gnt, rvalid and err outputs 0.
  - ram_req_o=0.
  - All rdata outputs 0.
- Grants are gated low while rst_sys_n is low.
- Latency: grant at cycle N, rvalid plus rdata at cycle N+1. No other latency exists.
- Reset asserted between grant and rvalid discards the response, and no rvalid is issued after release.
- The first grant is possible in the first clock edge cycle after release.
- A simultaneous grant at cycle N and response at cycle N, for an earlier grant, is normal overlap and must not corrupt either transfer.
- The starvation counter saturates at 15 and never wraps.

## Test plan
- **Single read:** instr_req at 0x0000_0080 with RAM word 32 = 0xDEADBEEF.
  - instr_gnt is 1 in the same cycle, ram_addr_o=32.
  - Next cycle: instr_rvalid=1, instr_rdata=0xDEADBEEF, err=0.
- **Byte write:** data write to 0x104 with be=4'b0010 and wdata=0x0000AB00, over a word holding 0x11223344.
  - data_rvalid follows one cycle later.
  - A readback returns 0x1122AB44.
- **Contention:** instr, data and cust all request continuously.
  - instr is granted for 8 cycles.
  - On cycle 9, data is boosted and granted, and its counter clears.
  - cust is boosted after data, on the first cycle in which data is not itself boosted.
- **Out of range:** data read at 0x0001_0000.
  - data_gnt=1 and ram_req_o=0.
  - Next cycle: data_rvalid=1, data_err=1, data_rdata=0.
  - An out-of-range write leaves RAM unchanged.
- **Custom write then read:** cust write to index 0x3FFF with 0xCAFEF00D, then a cust read.
  - Each access gets a cust_rvalid pulse.
  - The read returns 0xCAFEF00D.
- **Reset mid-flight:** assert rst_sys_n low in the cycle after a data grant.
  - No data_rvalid occurs.
  - All outputs are 0 during reset.
  - After release, a fresh instr read completes normally.
